// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: default datapath widths, the hardwired-zero
// register index and common word/index types.
package mips_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_ADDR_WIDTH = 5;
    localparam int unsigned REG_ZERO       = 0;

    typedef logic [DEF_ADDR_WIDTH-1:0] regIndex_t;
    typedef logic [DEF_DATA_WIDTH-1:0] word_t;

endpackage

// File: rtl/Mux2To1.sv
// Generic two-input word multiplexer: select=0 passes input0, select=1 passes input1.
module Mux2To1 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             select,
    input  logic [WIDTH-1:0] input0,
    input  logic [WIDTH-1:0] input1,
    output logic [WIDTH-1:0] out
);

    always_comb begin
        out = select ? input1 : input0;
    end

endmodule

// File: rtl/register_file_decode_read_port.sv
// One asynchronous register-file read port: forces index 0 to zero and, when
// REGFILE_WRITE_BYPASS_EN is defined, forwards same-cycle write-back data.
module register_file_read_port
    import mips_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_row,
`ifdef REGFILE_WRITE_BYPASS_EN
    input  logic [DATA_WIDTH-1:0] wb_data,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic                  wb_commit,
`endif
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] selected;
    logic                  is_zero;

    assign is_zero = (rd_addr == ADDR_WIDTH'(REG_ZERO));

`ifdef REGFILE_WRITE_BYPASS_EN
    logic hit;

    // wb_commit already excludes index 0 and reset, so a hit is a true collision
    assign hit = wb_commit && (wb_addr == rd_addr);

    Mux2To1 #(
        .WIDTH(DATA_WIDTH)
    ) u_bypass_mux (
        .select(hit),
        .input0(rd_row),
        .input1(wb_data),
        .out   (selected)
    );
`else
    assign selected = rd_row;
`endif

    always_comb begin
        rd_data = is_zero ? '0 : selected;
    end

endmodule

// File: rtl/register_file_decode.sv
// Decode-stage register file: write-back commit port, two async read ports and a
// saturating commit counter. Define REGFILE_WRITE_BYPASS_EN for write-through reads.
module register_file_decode
    import mips_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] dataToWriteRegisterFile_WriteBack,
    input  logic [ADDR_WIDTH-1:0] addressWriteRegisterFile_WriteBack,
    input  logic                  enableWriteRegisterFile_WriteBack,
    input  logic [ADDR_WIDTH-1:0] addressReadRs_Decode,
    input  logic [ADDR_WIDTH-1:0] addressReadRt_Decode,
    output logic [DATA_WIDTH-1:0] dataReadRs_Decode,
    output logic [DATA_WIDTH-1:0] dataReadRt_Decode,
    output logic [31:0]           writeCount_Decode
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DATA_WIDTH-1:0] regs_d [DEPTH];
    logic [31:0]           write_count_q;
    logic [31:0]           write_count_d;
    logic                  wb_commit;

    assign wb_commit = enableWriteRegisterFile_WriteBack
                    && (addressWriteRegisterFile_WriteBack != ADDR_WIDTH'(REG_ZERO));

    always_comb begin
        regs_d = regs_q;
        if (wb_commit) begin
            regs_d[addressWriteRegisterFile_WriteBack] = dataToWriteRegisterFile_WriteBack;
        end
        write_count_d = write_count_q;
        if (wb_commit && (write_count_q != '1)) begin
            write_count_d = write_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q        <= '{default: '0};
            write_count_q <= '0;
        end else begin
            regs_q        <= regs_d;
            write_count_q <= write_count_d;
        end
    end

    assign writeCount_Decode = write_count_q;

`ifdef REGFILE_WRITE_BYPASS_EN
    logic bypass_commit;

    // Gating with rst_n keeps reads at zero while reset is held
    assign bypass_commit = wb_commit && rst_n;
`endif

    register_file_read_port #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_rs_port (
        .rd_addr  (addressReadRs_Decode),
        .rd_row   (regs_q[addressReadRs_Decode]),
`ifdef REGFILE_WRITE_BYPASS_EN
        .wb_data  (dataToWriteRegisterFile_WriteBack),
        .wb_addr  (addressWriteRegisterFile_WriteBack),
        .wb_commit(bypass_commit),
`endif
        .rd_data  (dataReadRs_Decode)
    );

    register_file_read_port #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_rt_port (
        .rd_addr  (addressReadRt_Decode),
        .rd_row   (regs_q[addressReadRt_Decode]),
`ifdef REGFILE_WRITE_BYPASS_EN
        .wb_data  (dataToWriteRegisterFile_WriteBack),
        .wb_addr  (addressWriteRegisterFile_WriteBack),
        .wb_commit(bypass_commit),
`endif
        .rd_data  (dataReadRt_Decode)
    );

    wb_known_a: assert property (@(posedge clk) disable iff (!rst_n)
        !$isunknown(enableWriteRegisterFile_WriteBack)
        && (!enableWriteRegisterFile_WriteBack || !$isunknown(addressWriteRegisterFile_WriteBack)));

endmodule

// File: tb/tb_register_file_decode.sv
// Directed self-checking bench for register_file_decode; the collision scenario
// follows REGFILE_WRITE_BYPASS_EN.
module tb_register_file_decode;
    import mips_pkg::*;

    logic      clk;
    logic      rst_n;
    word_t     wb_data;
    regIndex_t wb_addr;
    logic      wb_en;
    regIndex_t rs_addr;
    regIndex_t rt_addr;
    word_t     rs_data;
    word_t     rt_data;
    logic [31:0] wcount;

    int unsigned checks = 0;
    int unsigned passes = 0;

    register_file_decode #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(5)
    ) dut (
        .clk                               (clk),
        .rst_n                             (rst_n),
        .dataToWriteRegisterFile_WriteBack (wb_data),
        .addressWriteRegisterFile_WriteBack(wb_addr),
        .enableWriteRegisterFile_WriteBack (wb_en),
        .addressReadRs_Decode              (rs_addr),
        .addressReadRt_Decode              (rt_addr),
        .dataReadRs_Decode                 (rs_data),
        .dataReadRt_Decode                 (rt_data),
        .writeCount_Decode                 (wcount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d checks", passes, checks);
        $fatal(1);
    end

    // Drive one write-back beat and let it pass the next rising edge.
    task automatic wb_beat(input logic en, input regIndex_t addr, input word_t data);
        wb_en   = en;
        wb_addr = addr;
        wb_data = data;
        @(posedge clk);
        #1;
    endtask

    task automatic wb_idle();
        wb_en   = 1'b0;
        wb_addr = '0;
        wb_data = '0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        wb_beat(1'b1, 5'd5, 32'hDEADBEEF);
        wb_idle();
        rs_addr = 5'd5;
        rt_addr = 5'd5;
        #1;
        checks++;
        if (rs_data !== 32'hDEADBEEF) $display("FAIL reset_pre_write: got %h want %h", rs_data, 32'hDEADBEEF);
        else passes++;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (rs_data !== 32'h0) $display("FAIL reset_rs: got %h want %h", rs_data, 32'h0);
        else passes++;
        checks++;
        if (rt_data !== 32'h0) $display("FAIL reset_rt: got %h want %h", rt_data, 32'h0);
        else passes++;
        checks++;
        if (wcount !== 32'h0) $display("FAIL reset_count: got %h want %h", wcount, 32'h0);
        else passes++;
        wb_beat(1'b1, 5'd5, 32'h0000ABCD);
        wb_idle();
        checks++;
        if (rs_data !== 32'h0) $display("FAIL reset_write_ignored: got %h want %h", rs_data, 32'h0);
        else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (rs_data !== 32'h0) $display("FAIL reset_release_rs: got %h want %h", rs_data, 32'h0);
        else passes++;
        checks++;
        if (wcount !== 32'h0) $display("FAIL reset_release_count: got %h want %h", wcount, 32'h0);
        else passes++;
    endtask

    task automatic test_write_read();
        @(negedge clk);
        rs_addr = 5'd7;
        rt_addr = 5'd3;
        wb_beat(1'b1, 5'd7, 32'h12345678);
        wb_idle();
        checks++;
        if (rs_data !== 32'h12345678) $display("FAIL write_read_rs7: got %h want %h", rs_data, 32'h12345678);
        else passes++;
        checks++;
        if (rt_data !== 32'h0) $display("FAIL write_read_rt3: got %h want %h", rt_data, 32'h0);
        else passes++;
        checks++;
        if (wcount !== 32'd1) $display("FAIL write_read_count: got %0d want %0d", wcount, 1);
        else passes++;
        wb_beat(1'b1, 5'd31, 32'hA5A5C3C3);
        wb_idle();
        rt_addr = 5'd31;
        #1;
        checks++;
        if (rt_data !== 32'hA5A5C3C3) $display("FAIL write_read_rt31: got %h want %h", rt_data, 32'hA5A5C3C3);
        else passes++;
        checks++;
        if (rs_data !== 32'h12345678) $display("FAIL write_read_rs7_kept: got %h want %h", rs_data, 32'h12345678);
        else passes++;
        checks++;
        if (wcount !== 32'd2) $display("FAIL write_read_count2: got %0d want %0d", wcount, 2);
        else passes++;
    endtask

    task automatic test_zero_register();
        @(negedge clk);
        rs_addr = 5'd0;
        rt_addr = 5'd0;
        wb_en   = 1'b1;
        wb_addr = 5'd0;
        wb_data = 32'hFFFFFFFF;
        #1;
        checks++;
        if (rs_data !== 32'h0) $display("FAIL zero_same_cycle_rs: got %h want %h", rs_data, 32'h0);
        else passes++;
        @(posedge clk);
        #1;
        wb_idle();
        checks++;
        if (rs_data !== 32'h0) $display("FAIL zero_rs: got %h want %h", rs_data, 32'h0);
        else passes++;
        checks++;
        if (rt_data !== 32'h0) $display("FAIL zero_rt: got %h want %h", rt_data, 32'h0);
        else passes++;
        checks++;
        if (wcount !== 32'd2) $display("FAIL zero_count: got %0d want %0d", wcount, 2);
        else passes++;
    endtask

    task automatic test_collision();
        word_t expect_before;
        @(negedge clk);
        wb_beat(1'b1, 5'd9, 32'h1);
        wb_idle();
        @(negedge clk);
        rs_addr = 5'd9;
        rt_addr = 5'd9;
        wb_en   = 1'b1;
        wb_addr = 5'd9;
        wb_data = 32'h2;
        #1;
`ifdef REGFILE_WRITE_BYPASS_EN
        expect_before = 32'h2;
`else
        expect_before = 32'h1;
`endif
        checks++;
        if (rs_data !== expect_before) $display("FAIL collision_before_rs: got %h want %h", rs_data, expect_before);
        else passes++;
        checks++;
        if (rt_data !== expect_before) $display("FAIL collision_before_rt: got %h want %h", rt_data, expect_before);
        else passes++;
        @(posedge clk);
        #1;
        wb_idle();
        #1;
        checks++;
        if (rs_data !== 32'h2) $display("FAIL collision_after_rs: got %h want %h", rs_data, 32'h2);
        else passes++;
        checks++;
        if (rt_data !== 32'h2) $display("FAIL collision_after_rt: got %h want %h", rt_data, 32'h2);
        else passes++;
        checks++;
        if (wcount !== 32'd4) $display("FAIL collision_count: got %0d want %0d", wcount, 4);
        else passes++;
    endtask

    task automatic test_back_to_back_reset();
        @(negedge clk);
        rs_addr = 5'd1;
        rt_addr = 5'd4;
        wb_beat(1'b1, 5'd1, 32'h11);
        wb_beat(1'b1, 5'd2, 32'h22);
        wb_beat(1'b1, 5'd3, 32'h33);
        wb_beat(1'b1, 5'd4, 32'h44);
        wb_en   = 1'b1;
        wb_addr = 5'd5;
        wb_data = 32'h55;
        checks++;
        if (rs_data !== 32'h11) $display("FAIL b2b_rs1: got %h want %h", rs_data, 32'h11);
        else passes++;
        checks++;
        if (rt_data !== 32'h44) $display("FAIL b2b_rt4: got %h want %h", rt_data, 32'h44);
        else passes++;
        checks++;
        if (wcount !== 32'd8) $display("FAIL b2b_count: got %0d want %0d", wcount, 8);
        else passes++;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (rs_data !== 32'h0) $display("FAIL async_rs_cleared: got %h want %h", rs_data, 32'h0);
        else passes++;
        checks++;
        if (rt_data !== 32'h0) $display("FAIL async_rt_cleared: got %h want %h", rt_data, 32'h0);
        else passes++;
        checks++;
        if (wcount !== 32'h0) $display("FAIL async_count_cleared: got %h want %h", wcount, 32'h0);
        else passes++;
        wb_beat(1'b1, 5'd6, 32'h66);
        wb_idle();
        @(negedge clk);
        rst_n   = 1'b1;
        rs_addr = 5'd5;
        rt_addr = 5'd6;
        #1;
        checks++;
        if (rs_data !== 32'h0) $display("FAIL async_reg5_dropped: got %h want %h", rs_data, 32'h0);
        else passes++;
        checks++;
        if (rt_data !== 32'h0) $display("FAIL async_reg6_dropped: got %h want %h", rt_data, 32'h0);
        else passes++;
        checks++;
        if (wcount !== 32'h0) $display("FAIL async_count_after: got %h want %h", wcount, 32'h0);
        else passes++;
    endtask

    task automatic test_counter_saturation();
        @(negedge clk);
        force dut.write_count_q = 32'hFFFFFFFE;
        #1;
        release dut.write_count_q;
        rs_addr = 5'd12;
        rt_addr = 5'd10;
        wb_beat(1'b1, 5'd10, 32'hCAFE0010);
        checks++;
        if (wcount !== 32'hFFFFFFFF) $display("FAIL sat_first: got %h want %h", wcount, 32'hFFFFFFFF);
        else passes++;
        wb_beat(1'b1, 5'd11, 32'hCAFE0011);
        checks++;
        if (wcount !== 32'hFFFFFFFF) $display("FAIL sat_second: got %h want %h", wcount, 32'hFFFFFFFF);
        else passes++;
        wb_beat(1'b1, 5'd12, 32'hCAFE0012);
        wb_idle();
        checks++;
        if (wcount !== 32'hFFFFFFFF) $display("FAIL sat_third: got %h want %h", wcount, 32'hFFFFFFFF);
        else passes++;
        checks++;
        if (rs_data !== 32'hCAFE0012) $display("FAIL sat_rs12: got %h want %h", rs_data, 32'hCAFE0012);
        else passes++;
        checks++;
        if (rt_data !== 32'hCAFE0010) $display("FAIL sat_rt10: got %h want %h", rt_data, 32'hCAFE0010);
        else passes++;
        @(posedge clk);
        #1;
        checks++;
        if (wcount !== 32'hFFFFFFFF) $display("FAIL sat_hold: got %h want %h", wcount, 32'hFFFFFFFF);
        else passes++;
    endtask

    initial begin
        rst_n   = 1'b0;
        rs_addr = '0;
        rt_addr = '0;
        wb_idle();
        repeat (2) @(posedge clk);
        test_reset();
        test_write_read();
        test_zero_register();
        test_collision();
        test_back_to_back_reset();
        test_counter_saturation();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
